// File: rtl/afpm_pkg.sv
// Shared definitions for the serial logarithmic approximate FP multiplier.
//   - afpm_state_e : wrapper FSM states (LOAD, CALC, OUT)
//   - DEF_*        : default field/beat widths (binary16 on an 8-bit bus)
//   - FLAG_*       : bit positions inside the {ovf, unf, zero} flag vector
//   - afpm_bias()  : exponent bias for a given exponent width
package afpm_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        OUT  = 2'd2
    } afpm_state_e;

    localparam int DEF_EW    = 5;
    localparam int DEF_MW    = 10;
    localparam int DEF_BUS_W = 8;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_UNF  = 1;
    localparam int FLAG_OVF  = 2;

    function automatic int afpm_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

endpackage

// File: rtl/afpm_log_core.sv
// Combinational Mitchell-style FP product: sign XOR, exponent add,
// mantissa add (no multiplier array). Subnormal operands flush to zero.
// Optional build macro: AFPM_SPECIALS_EN (Inf/NaN handling on the
// all-ones exponent; without it that exponent is an ordinary finite value).
// Ports:
//   a, b    in  [W-1:0]  operands {sign, exp[EW], mant[MW]}
//   product out [W-1:0]  approximate product
//   flags   out [2:0]    {ovf, unf, zero}
module afpm_log_core
    import afpm_pkg::*;
#(
    parameter int EW = DEF_EW,
    parameter int MW = DEF_MW,
    localparam int W = 1 + EW + MW
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] product,
    output logic [2:0]   flags
);

    localparam int BIAS = afpm_bias(EW);
    localparam logic signed [EW+1:0] BIAS_S = (EW+2)'(BIAS);
    localparam logic signed [EW+1:0] ONE_S  = (EW+2)'(1);
`ifdef AFPM_SPECIALS_EN
    // all-ones exponent is reserved, so the finite range stops one below it
    localparam logic signed [EW+1:0] EMAX_S = (EW+2)'((1 << EW) - 2);
`else
    localparam logic signed [EW+1:0] EMAX_S = (EW+2)'((1 << EW) - 1);
`endif

    logic          s;
    logic [EW-1:0] ea, eb;
    logic [MW-1:0] ma, mb;
    logic [MW:0]   msum;
    logic signed [EW+1:0] er;

    assign s  = a[W-1] ^ b[W-1];
    assign ea = a[W-2:MW];
    assign eb = b[W-2:MW];
    assign ma = a[MW-1:0];
    assign mb = b[MW-1:0];

    // mantissa carry lands in the exponent: (1+x)(1+y) ~ 2*(1+(x+y-1)) when x+y>=1
    assign msum = {1'b0, ma} + {1'b0, mb};
    assign er   = $signed({2'b00, ea} + {2'b00, eb} + {{(EW+1){1'b0}}, msum[MW]}) - BIAS_S;

`ifdef AFPM_SPECIALS_EN
    logic a_ones, b_ones, a_nan, b_nan, a_inf, b_inf;
    assign a_ones = &ea;
    assign b_ones = &eb;
    assign a_nan  = a_ones && (ma != '0);
    assign b_nan  = b_ones && (mb != '0);
    assign a_inf  = a_ones && (ma == '0);
    assign b_inf  = b_ones && (mb == '0);
`endif

    always_comb begin
        product = {s, {(W-1){1'b0}}};
        flags   = 3'b000;
`ifdef AFPM_SPECIALS_EN
        if (a_nan || b_nan || (a_inf && eb == '0) || (b_inf && ea == '0)) begin
            product = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
        end else if (a_inf || b_inf) begin
            product = {s, {EW{1'b1}}, {MW{1'b0}}};
        end else
`endif
        if (ea == '0 || eb == '0) begin
            flags[FLAG_ZERO] = 1'b1;
        end else if (er < ONE_S) begin
            flags[FLAG_UNF] = 1'b1;
        end else if (er > EMAX_S) begin
            flags[FLAG_OVF] = 1'b1;
`ifdef AFPM_SPECIALS_EN
            product = {s, {EW{1'b1}}, {MW{1'b0}}};
`else
            product = {s, {(W-1){1'b1}}};
`endif
        end else begin
            product = {s, er[EW-1:0], msum[MW-1:0]};
        end
    end

endmodule

// File: rtl/afpm_log_mul_serial.sv
// Byte-serial wrapper around afpm_log_core. Operands arrive LSB beat first
// (LOAD), the product is registered in one cycle (CALC), then returned LSB
// beat first under valid/ready (OUT). Input and output never overlap.
// Optional build macro: AFPM_SPECIALS_EN (forwarded to afpm_log_core).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_a, in_b [BUS_W]    operand beats, accepted when in_valid && in_ready
//   out_data [BUS_W]      result beat, held until out_ready
//   out_valid, out_last   beat valid / final beat marker
//   out_ready             downstream accept
//   out_flags [3]         {ovf, unf, zero} of the current result
module afpm_log_mul_serial
    import afpm_pkg::*;
#(
    parameter int EW    = DEF_EW,
    parameter int MW    = DEF_MW,
    parameter int BUS_W = DEF_BUS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BUS_W-1:0] in_a,
    input  logic [BUS_W-1:0] in_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [BUS_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [2:0]       out_flags
);

    localparam int W      = 1 + EW + MW;
    localparam int NBEATS = W / BUS_W;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBEATS - 1);

    afpm_state_e   state, state_n;
    logic [CW-1:0] cnt;
    logic [W-1:0]  a_q, b_q, res_q;
    logic [2:0]    flags_q;
    logic [W-1:0]  core_p;
    logic [2:0]    core_f;
    logic          cnt_last;

    assign cnt_last = (cnt == LAST);

    afpm_log_core #(.EW(EW), .MW(MW)) u_core (
        .a       (a_q),
        .b       (b_q),
        .product (core_p),
        .flags   (core_f)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt_last) state_n = CALC;
            end
            CALC: state_n = OUT;
            OUT: begin
                out_valid = 1'b1;
                out_last  = cnt_last;
                if (out_ready && cnt_last) state_n = LOAD;
            end
            default: state_n = LOAD;
        endcase
    end

    // one beat counter serves both directions since LOAD and OUT never overlap
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                LOAD: if (in_valid) begin
                    a_q[cnt*BUS_W +: BUS_W] <= in_a;
                    b_q[cnt*BUS_W +: BUS_W] <= in_b;
                    cnt <= cnt_last ? '0 : cnt + CW'(1);
                end
                CALC: begin
                    res_q   <= core_p;
                    flags_q <= core_f;
                end
                OUT: if (out_ready) cnt <= cnt_last ? '0 : cnt + CW'(1);
                default: ;
            endcase
        end
    end

    assign out_data  = (state == OUT) ? res_q[cnt*BUS_W +: BUS_W] : '0;
    assign out_flags = flags_q;

endmodule

// File: doc/afpm_log_mul_serial.md
Name: afpm_log_mul_serial

Overview:
Parametrised successor to the fixed 16-bit logarithmic approximate FP multiplier.
- Collects two operands byte-serially, LSB beat first.
- Forms a Mitchell-approximation product: exponent add plus mantissa add, with no multiplier array.
- Returns the result byte-serially under a valid/ready handshake.
- Sits between the pad-level wrapper (ui_in/uio_in/uo_out) and the operand source.

Parameters:
EW, 5, exponent field width (>=3)
MW, 10, mantissa field width (>=2)
BUS_W, 8, beat width; W=1+EW+MW must be a multiple of BUS_W
(derived) W=1+EW+MW; NBEATS=W/BUS_W; BIAS=2^(EW-1)-1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
in_a  in  BUS_W  operand A beat
in_b  in  BUS_W  operand B beat
in_valid  in  1  input beat valid
in_ready  out  1  block accepts an input beat
out_data  out  BUS_W  result beat
out_valid  out  1  result beat valid
out_last  out  1  final result beat
out_ready  in  1  downstream accepts the result beat
out_flags  out  3  {ovf, unf, zero}; stable while out_valid

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
- Reset: state=LOAD, beat counter=0, operand and result registers=0.
- Reset outputs: in_ready=1, out_valid=0, out_last=0, out_data=0, out_flags=0.
- Reset mid-operation discards partial operands and any pending result.
- FSM LOAD:
  - in_ready=1.
  - Each in_valid beat writes in_a and in_b into slice [cnt*BUS_W +: BUS_W] and increments cnt.
  - On beat NBEATS-1, cnt wraps to 0 and the FSM goes to CALC.
- FSM CALC (1 cycle):
  - in_ready=0.
  - Core result and flags are registered, then the FSM goes to OUT.
- FSM OUT:
  - out_valid=1; out_data = result slice cnt, LSB first.
  - out_last=1 when cnt==NBEATS-1.
  - The beat is held unchanged until out_ready.
  - On out_ready with out_last, cnt goes to 0 and the FSM returns to LOAD.
  - in_ready=0 throughout OUT; there is no overlap of input and output.
- Latency: last input beat accepted at edge t → first out_valid at edge t+2. Throughput is one product per 2*NBEATS+1 cycles when out_ready is held at 1.
- Arithmetic:
  - s = sa^sb.
  - If ea==0 or eb==0: result {s,0...}, zero=1. Subnormals are flushed.
  - Otherwise msum = ma+mb (MW+1 bits) and c = msum[MW].
  - mr = msum[MW-1:0], i.e. msum-2^MW when c=1.
  - er = ea+eb-BIAS+c, computed signed, EW+2 bits.
  - er<1 → {s,0...}, unf=1.
  - er>2^EW-1 → saturate to {s, all-ones exp, all-ones mant}, ovf=1.
  - Otherwise result = {s, er[EW-1:0], mr}.
- Exponent all-ones is treated as an ordinary finite exponent unless the optional feature is enabled.

Optional Feature:
AFPM_SPECIALS_EN
- Defined:
  - Exponent all-ones is Inf (mant==0) or NaN (mant!=0).
  - Any NaN operand, or Inf×zero, gives canonical NaN {0, all-ones exp, 1 followed by zeros}.
  - Inf×finite-nonzero gives {s, all-ones exp, 0}.
  - Overflow yields {s, all-ones exp, 0}, ovf=1; the finite range tops out at exponent 2^EW-2.
  - out_flags gains no bits.
- Undefined: behaviour exactly as in Behaviour; no special-value logic is present.

Decomposition:
- Package afpm_pkg holds:
  - FSM state enum (LOAD, CALC, OUT).
  - Default EW/MW/BUS_W constants.
  - Flag bit-index constants.
  - The BIAS derivation function.
- Sub-module afpm_log_core: purely combinational, parametrised by EW/MW. Takes operands a and b; returns product and flags. The wrapper FSM owns all registers.

Test Plan:
- 0x44DF × 0x483D (beats DF/3D, then 44/48) → out beats 0x1C, 0x51 (0x511C). out_last on the 2nd beat; first out_valid 2 cycles after the last input beat; flags 000.
- 0x3E00 × 0x3E00 (1.5×1.5) → 0x4000 (mantissa carry path, exponent 16).
- 0xBC00 × 0x4000 → 0xC000. Separately, 0x8000 × 0x44DF → 0x8000 with zero=1.
- 0x7800 × 0x7800 → 0x7FFF with ovf=1. With AFPM_SPECIALS_EN → 0x7C00. Separately, 0x0400 × 0x0400 → 0x0000 with unf=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles on beat 0: out_data is stable, in_ready=0, and no beat is lost.
  - Assert rst after one input beat, then send a full operand pair: the result matches a clean run.
